// File: rtl/ahb_resp_mux_if.sv
// Response-path bundle between the AHB-Lite subordinate fabric and the response mux.
// HREADY is the transfer handshake: an address phase is accepted, and a data phase completes, only on an HCLK edge where HREADY = 1; while HREADY = 0 the manager must hold its address/control and everything downstream of the mux holds too.
interface ahb_resp_mux_if #(
  parameter int DATA_WIDTH         = 32,
  parameter int NO_OF_SUBORDINATES = 6
);
  logic [NO_OF_SUBORDINATES-1:0]            HSEL_VEC;
  logic [1:0]                               HTRANS;
  logic [NO_OF_SUBORDINATES*DATA_WIDTH-1:0] HRDATA_S;
  logic [NO_OF_SUBORDINATES-1:0]            HREADYOUT_S;
  logic [NO_OF_SUBORDINATES-1:0]            HRESP_S;
  logic [DATA_WIDTH-1:0]                    HRDATA;
  logic                                     HREADY;
  logic                                     HRESP;
  logic                                     SEL_ERR;
  logic [1:0]                               dflt_state_dbg;

  modport slave (
    input  HSEL_VEC, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    output HRDATA, HREADY, HRESP, SEL_ERR, dflt_state_dbg
  );

  modport master (
    output HSEL_VEC, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
    input  HRDATA, HREADY, HRESP, SEL_ERR, dflt_state_dbg
  );
endinterface

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response mux with built-in default (unmapped-region) ERROR responder.
// Optional multi-select check enabled by defining AHB_RESP_MUX_ONEHOT_CHK_EN.
module ahb_resp_mux #(
  parameter int DATA_WIDTH         = 32,
  parameter int NO_OF_SUBORDINATES = 6
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_resp_mux_if.slave bus
);
  localparam int N = NO_OF_SUBORDINATES;
  localparam logic [N:0] DSEL_DFLT = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {
    D_OK   = 2'd0,
    D_ERR1 = 2'd1,
    D_ERR2 = 2'd2
  } dflt_state_e;

  dflt_state_e           state_q, state_d;
  logic [N:0]            dsel_q, dsel_d;
  logic [N-1:0]          sel_pri;
  logic                  any_sel;
  logic                  dflt_ready, dflt_resp;
  logic                  advance;
  logic                  hready, hresp;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  unused_htrans0;

  assign unused_htrans0 = bus.HTRANS[0];
  assign any_sel        = |bus.HSEL_VEC;

  // Scan high-to-low so the lowest set index is the last (winning) write.
  always_comb begin
    sel_pri = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.HSEL_VEC[i]) begin
        sel_pri    = '0;
        sel_pri[i] = 1'b1;
      end
    end
  end

  always_comb begin
    dflt_ready = 1'b1;
    dflt_resp  = 1'b0;
    case (state_q)
      D_ERR1: begin
        dflt_ready = 1'b0;
        dflt_resp  = 1'b1;
      end
      D_ERR2:  dflt_resp = 1'b1;
      default: ;
    endcase

    hrdata = '0;
    hready = dflt_ready;
    hresp  = dflt_resp;
    for (int i = 0; i < N; i++) begin
      if (dsel_q[i]) begin
        hrdata = bus.HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        hready = bus.HREADYOUT_S[i];
        hresp  = bus.HRESP_S[i];
      end
    end

    dsel_d = dsel_q;
    if (hready) dsel_d = any_sel ? {1'b0, sel_pri} : DSEL_DFLT;

    // The responder only moves while it owns, or is about to own, the data phase.
    advance = dsel_q[N] | (hready & ~any_sel);
    state_d = state_q;
    if (advance) begin
      case (state_q)
        D_ERR1:  state_d = D_ERR2;
        default: state_d = (hready && !any_sel && bus.HTRANS[1]) ? D_ERR1 : D_OK;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel_q  <= DSEL_DFLT;
      state_q <= D_OK;
    end else begin
      dsel_q  <= dsel_d;
      state_q <= state_d;
    end
  end

  assign bus.HRDATA         = hrdata;
  assign bus.HREADY         = hready;
  assign bus.HRESP          = hresp;
  assign bus.dflt_state_dbg = state_q;

`ifdef AHB_RESP_MUX_ONEHOT_CHK_EN
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  logic sel_err_q, sel_err_d;

  // v & (v-1) is non-zero exactly when more than one bit is set.
  assign sel_err_d = sel_err_q | (hready & (|(bus.HSEL_VEC & (bus.HSEL_VEC - ONE))));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) sel_err_q <= 1'b0;
    else          sel_err_q <= sel_err_d;
  end

  assign bus.SEL_ERR = sel_err_q;
`else
  assign bus.SEL_ERR = 1'b0;
`endif
endmodule
